regs_scb: RTL and testbench
===========================

// Module: regs_scb
// PURPOSE
//  Parametrised general-register file for the pipelined core: RD_PORTS combinational read ports
//  for the READ stage and one write port from WRITE_BACK. Same-cycle write-to-read bypass.
//  Per-register pending scoreboard: issue reserves a destination, write-back releases it, and
//  READ stalls on busy operands. Optional hardwired-zero register 0.
// PARAMETERS
//  D_BITS    32  data width of each register
//  REG_NR    8   number of registers (>=2, need not be a power of 2)
//  RD_PORTS  2   number of read ports (1..4)
//  ZERO_REG  0   1: reg 0 reads 0, ignores writes/reserves, never pending
//  AW (localparam) = $clog2(REG_NR), index width
// PORTS
//  clk_i          in   1              clock, all state on rising edge
//  rst_i          in   1              synchronous reset, active-high
//  regs_start_i   in   1              read enable; 0 forces all operand_o/busy_o to 0
//  src_i          in   RD_PORTS*AW    read indices, port p at [p*AW +: AW]
//  operand_o      out  RD_PORTS*D_BITS  read data, port p at [p*D_BITS +: D_BITS]
//  busy_o         out  RD_PORTS       port p source pending (READ must stall)
//  wen_i          in   1              write enable
//  dest_i         in   AW             write index
//  result_i       in   D_BITS         write data
//  rsv_i          in   1              reserve request (instruction issued)
//  rsv_dest_i     in   AW             register to mark pending
//  flush_i        in   1              clear all pending bits (pipeline flush)
//  pending_o      out  REG_NR         current pending vector (registered state)
// BEHAVIOUR
//  Reset (rst_i=1 at edge): all registers <= 0, pending <= 0. With the reset state, operand_o = 0,
//   busy_o = 0 and pending_o = 0. Reset overrides wen_i/rsv_i/flush_i in that cycle.
//  Read (combinational, 0 latency), per port p, only while regs_start_i=1:
//   idx >= REG_NR, or ZERO_REG && idx==0: operand 0, busy 0.
//   else if wen_i && dest_i==idx (valid write): operand = result_i (bypass), busy 0.
//   else: operand = reg[idx], busy = pending[idx].
//   All ports are independent; any ports may share an index.
//  Write (edge): wen_i && valid dest -> reg[dest_i] <= result_i. wen_i=0 -> no register changes.
//   Valid dest means dest_i < REG_NR and not (ZERO_REG && dest_i==0); invalid writes are dropped silently.
//  Pending update (edge), in priority order:
//   1. flush_i=1: pending <= 0; the rsv_i in the same cycle is dropped. The data write still occurs.
//   2. rsv_i with a valid rsv_dest_i: pending[rsv_dest_i] <= 1 (set beats clear on the same index).
//   3. wen_i with a valid dest_i: pending[dest_i] <= 0 unless case 2 targets the same index.
//   Writing a non-pending register is legal and leaves pending at 0.
//   A reserve of an already-pending register keeps it at 1. No counting; a single write releases it.
//  A reserve affects busy_o from the next cycle only. The same-cycle bypass is based on wen_i, not on rsv_i.
//  There is no combinational path from rsv_i/flush_i to any output.
// TESTING
//  1. Reset, then read all regs on every port with regs_start_i=1 -> operand 0, busy 0, pending_o 0.
//  2. Write reg3=0xDEAD_BEEF while port0 src=3 in the same cycle -> operand0 = 0xDEADBEEF (bypass).
//     The next cycle with wen_i=0 -> still 0xDEADBEEF.
//  3. rsv reg5; next cycle src=5 -> busy 1; write reg5=0x55 -> in that cycle busy 0 and operand 0x55;
//     the following cycle pending_o[5]=0.
//  4. Same cycle: rsv reg2 + write reg2=0x7 -> reg2=0x7 and pending_o[2]=1.
//     Same cycle: flush + rsv reg4 -> pending_o all 0.
//  5. ZERO_REG=1: write reg0=0xFFFF and rsv reg0 -> operand 0, busy 0, pending_o[0]=0.
//     REG_NR=6: src=7 -> 0, busy 0.
//  6. Pend regs 1, 2; assert rst_i mid-sequence -> next cycle all data 0, pending 0.
//     regs_start_i=0 at any time -> all operand_o/busy_o 0.

Source files
------------

// File: rtl/regs_scb.sv
// regs_scb: general-register file, RD_PORTS combinational read ports, one write port, pending scoreboard.
// Latency: reads are 0-cycle with same-cycle write bypass; writes/reserves/flush take effect at the next clk_i edge.
// Backpressure: none accepted; busy_o asks the READ stage to stall while a source register is pending.
module regs_scb #(
  parameter int D_BITS   = 32,
  parameter int REG_NR   = 8,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 0,
  localparam int AW      = (REG_NR > 1) ? $clog2(REG_NR) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         regs_start_i,
  input  logic [RD_PORTS*AW-1:0]       src_i,
  output logic [RD_PORTS*D_BITS-1:0]   operand_o,
  output logic [RD_PORTS-1:0]          busy_o,
  input  logic                         wen_i,
  input  logic [AW-1:0]                dest_i,
  input  logic [D_BITS-1:0]            result_i,
  input  logic                         rsv_i,
  input  logic [AW-1:0]                rsv_dest_i,
  input  logic                         flush_i,
  output logic [REG_NR-1:0]            pending_o
);

  // An index names a real register when it is in range and is not the hardwired zero register.
  function automatic logic idx_valid(input logic [AW-1:0] idx);
    return (int'(idx) < REG_NR) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  logic [D_BITS-1:0] regs_q [REG_NR];
  logic [D_BITS-1:0] regs_d [REG_NR];
  logic [REG_NR-1:0] pending_q;
  logic [REG_NR-1:0] pending_d;

  logic wr_ok;
  logic rsv_ok;

  // Write and reserve requests that target a real register; everything else is dropped silently.
  assign wr_ok  = wen_i && idx_valid(dest_i);
  assign rsv_ok = rsv_i && idx_valid(rsv_dest_i);

  assign pending_o = pending_q;

  // Next register contents: only a valid write changes one entry; flush does not cancel data writes.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[dest_i] = result_i;
    end
  end

  // Next pending vector: flush clears everything and drops the reserve; otherwise release then
  // reserve, so a reserve wins over a write-back release of the same register.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (wr_ok) begin
        pending_d[dest_i] = 1'b0;
      end
      if (rsv_ok) begin
        pending_d[rsv_dest_i] = 1'b1;
      end
    end
  end

  // State update; reset takes priority over any write, reserve or flush in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q    <= '{default: '0};
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  // Read ports are fully independent; the write-back value is forwarded to a port reading its
  // destination in the same cycle, which also hides the (about to be released) pending bit.
  // rsv_i and flush_i never reach these outputs combinationally.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0] rd_idx;
    assign rd_idx = src_i[p*AW +: AW];

    // Per-port operand and busy selection.
    always_comb begin
      operand_o[p*D_BITS +: D_BITS] = '0;
      busy_o[p]                     = 1'b0;
      if (regs_start_i && idx_valid(rd_idx)) begin
        if (wr_ok && (dest_i == rd_idx)) begin
          operand_o[p*D_BITS +: D_BITS] = result_i;
        end else begin
          operand_o[p*D_BITS +: D_BITS] = regs_q[rd_idx];
          busy_o[p]                     = pending_q[rd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regs_scb.sv
// Bench for regs_scb: two instances (8 regs plain, 6 regs with hardwired zero) driven in lockstep.
module tb_regs_scb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, wen, rsv, flush;
  logic [5:0]  src;
  logic [2:0]  dest, rsv_dest;
  logic [31:0] result;

  logic [63:0] op0, op1;
  logic [1:0]  busy0, busy1;
  logic [7:0]  pend0;
  logic [5:0]  pend1;

  int checks   = 0;
  int failures = 0;

  regs_scb #(.D_BITS(32), .REG_NR(8), .RD_PORTS(2), .ZERO_REG(0)) u0 (
    .clk_i(clk), .rst_i(rst), .regs_start_i(start), .src_i(src), .operand_o(op0),
    .busy_o(busy0), .wen_i(wen), .dest_i(dest), .result_i(result), .rsv_i(rsv),
    .rsv_dest_i(rsv_dest), .flush_i(flush), .pending_o(pend0));

  regs_scb #(.D_BITS(32), .REG_NR(6), .RD_PORTS(2), .ZERO_REG(1)) u1 (
    .clk_i(clk), .rst_i(rst), .regs_start_i(start), .src_i(src), .operand_o(op1),
    .busy_o(busy1), .wen_i(wen), .dest_i(dest), .result_i(result), .rsv_i(rsv),
    .rsv_dest_i(rsv_dest), .flush_i(flush), .pending_o(pend1));

  // Reference model: plain arrays per instance
  int          nr [2] = '{8, 6};
  int          zr [2] = '{0, 1};
  logic [31:0] md [2][8];
  logic        mp [2][8];

  function automatic logic vld(int k, logic [2:0] i);
    return (int'(i) < nr[k]) && !(zr[k] == 1 && i == 3'd0);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0]  idx;
    logic [31:0] eo, oo, ep, opv;
    logic        eb, ob;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        idx = src[p*3 +: 3];
        eo  = '0;
        eb  = 1'b0;
        if (start && vld(k, idx)) begin
          if (wen && vld(k, dest) && dest == idx) eo = result;
          else begin
            eo = md[k][idx];
            eb = mp[k][idx];
          end
        end
        oo = (k == 0) ? op0[p*32 +: 32] : op1[p*32 +: 32];
        ob = (k == 0) ? busy0[p] : busy1[p];
        chk($sformatf("operand k%0d p%0d src%0d", k, p, idx), oo, eo);
        chk($sformatf("busy k%0d p%0d src%0d", k, p, idx), {31'd0, ob}, {31'd0, eb});
      end
      ep = '0;
      for (int r = 0; r < nr[k]; r++) ep[r] = mp[k][r];
      opv = (k == 0) ? {24'd0, pend0} : {26'd0, pend1};
      chk($sformatf("pending k%0d", k), opv, ep);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int r = 0; r < 8; r++) begin
          md[k][r] = '0;
          mp[k][r] = 1'b0;
        end
      end else begin
        if (wen && vld(k, dest)) md[k][dest] = result;
        if (flush) begin
          for (int r = 0; r < 8; r++) mp[k][r] = 1'b0;
        end else begin
          if (wen && vld(k, dest)) mp[k][dest] = 1'b0;
          if (rsv && vld(k, rsv_dest)) mp[k][rsv_dest] = 1'b1;
        end
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1-2 time units later; model follows the rising edge.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; start = 1; wen = 0; rsv = 0; flush = 0;
    src = '0; dest = '0; rsv_dest = '0; result = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 0;

    // 1. reset state read on every port
    for (int i = 0; i < 8; i++) begin
      src = {3'(i), 3'(i)};
      #1;
      chk("rst op0", op0[31:0], 32'd0);
      chk("rst op1", op0[63:32], 32'd0);
      chk("rst busy", {30'd0, busy0}, 32'd0);
      step();
    end
    chk("rst pend", {24'd0, pend0}, 32'd0);

    // 2. same-cycle bypass then stored value
    wen = 1; dest = 3; result = 32'hDEAD_BEEF; src = {3'd0, 3'd3};
    #1; chk("bypass", op0[31:0], 32'hDEAD_BEEF);
    step();
    wen = 0;
    #1; chk("stored", op0[31:0], 32'hDEAD_BEEF);
    step();

    // 3. reserve, busy, release with bypass
    rsv = 1; rsv_dest = 5; src = {3'd0, 3'd5};
    step();
    rsv = 0;
    #1; chk("rsv busy", {31'd0, busy0[0]}, 32'd1);
    step();
    wen = 1; dest = 5; result = 32'h55;
    #1;
    chk("release busy", {31'd0, busy0[0]}, 32'd0);
    chk("release op", op0[31:0], 32'h55);
    step();
    wen = 0;
    #1; chk("release pend", {31'd0, pend0[5]}, 32'd0);
    step();

    // 4. reserve beats release; flush drops reserve
    rsv = 1; rsv_dest = 2; wen = 1; dest = 2; result = 32'h7;
    step();
    rsv = 0; wen = 0; src = {3'd2, 3'd2};
    #1;
    chk("rsv+wr pend", {31'd0, pend0[2]}, 32'd1);
    chk("rsv+wr busy", {31'd0, busy0[1]}, 32'd1);
    step();
    flush = 1; rsv = 1; rsv_dest = 4;
    step();
    flush = 0; rsv = 0;
    #1;
    chk("flush pend", {24'd0, pend0}, 32'd0);
    chk("flush keeps data", op0[31:0], 32'h7);
    step();

    // 5. hardwired zero and out-of-range index
    wen = 1; dest = 0; result = 32'hFFFF; rsv = 1; rsv_dest = 0; src = {3'd7, 3'd0};
    #1; chk("zr bypass", op1[31:0], 32'd0);
    step();
    wen = 0; rsv = 0;
    #1;
    chk("zr op", op1[31:0], 32'd0);
    chk("zr busy", {31'd0, busy1[0]}, 32'd0);
    chk("zr pend", {31'd0, pend1[0]}, 32'd0);
    chk("oor op", op1[63:32], 32'd0);
    chk("nozr pend0", {31'd0, pend0[0]}, 32'd1);
    step();

    // 6. reset mid-sequence and start gating
    rsv = 1; rsv_dest = 1; step();
    rsv_dest = 2; wen = 1; dest = 3; result = 32'h1234; step();
    rsv = 0; wen = 0; rst = 1; step();
    rst = 0; src = {3'd3, 3'd1};
    #1;
    chk("mid rst pend", {24'd0, pend0}, 32'd0);
    chk("mid rst data", op0[63:32], 32'd0);
    step();
    wen = 1; dest = 1; result = 32'hABCD; step();
    wen = 0; start = 0;
    #1; chk("start0 op", op0[31:0], 32'd0);
    step();

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      start    = ($urandom_range(0, 9) != 0);
      wen      = 1'($urandom_range(0, 1));
      dest     = 3'($urandom);
      result   = $urandom;
      rsv      = ($urandom_range(0, 2) != 0);
      rsv_dest = 3'($urandom);
      flush    = ($urandom_range(0, 24) == 0);
      src      = 6'($urandom);
      if ($urandom_range(0, 3) == 0) src[2:0] = dest;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
